// File: rtl/sc_io_pkg.sv
// Shared definitions for the data-memory / memory-mapped I/O block:
// I/O offsets, decode selector and the byte-merge helpers.
package sc_io_pkg;

    localparam int OUT_BASE = 0;
    localparam int IN_BASE  = 8;
    localparam int STAT_OFF = 16;
    localparam int CNT_OFF  = 17;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_OUT,
        SEL_IN,
        SEL_STAT,
        SEL_CNT
    } io_sel_e;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] m;
        m = be_mask(be);
        return (old_word & ~m) | (new_word & m);
    endfunction

    // Write-1-to-clear: a 1 in an enabled byte lane clears the matching bit.
    function automatic logic [31:0] w1c_merge(input logic [31:0] old_word,
                                              input logic [31:0] clr_word,
                                              input logic [3:0]  be);
        return old_word & ~(clr_word & be_mask(be));
    endfunction

endpackage

// File: rtl/io_input_sync.sv
// One input channel: three-stage synchroniser; value is stage 2 and change
// flags a difference between stages 2 and 3.
module io_input_sync #(
    parameter int IN_W = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [IN_W-1:0] raw,
    output logic [IN_W-1:0] value,
    output logic            change
);

    logic [IN_W-1:0] s1;
    logic [IN_W-1:0] s2;
    logic [IN_W-1:0] s3;

    // NOTE: non-blocking assignments let every stage sample its predecessor's
    // old value, giving a true shift chain instead of a single collapsed flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign value  = s2;
    assign change = (s2 != s3);

endmodule

// File: rtl/sc_datamem_io.sv
// Data RAM plus memory-mapped output registers, synchronised inputs with
// sticky change flags and a free-running cycle counter for the single-cycle CPU.
module sc_datamem_io
    import sc_io_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5,
    parameter int IO_BIT     = 7,
    parameter int NUM_OUT    = 3,
    parameter int NUM_IN     = 1,
    parameter int IN_W       = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            addr,
    input  logic [31:0]            datain,
    input  logic                   we,
    input  logic [3:0]             be,
    output logic [31:0]            dataout,
    output logic [NUM_OUT*32-1:0]  out_ports,
    input  logic [NUM_IN*IN_W-1:0] in_ports,
    output logic [NUM_IN-1:0]      in_change
);

    localparam int RAM_WORDS = 2 ** DEPTH_LOG2;

    logic [31:0]           mem [RAM_WORDS];
    logic [31:0]           out_reg [NUM_OUT];
    logic [IN_W-1:0]       in_val [NUM_IN];
    logic [NUM_IN-1:0]     change;
    logic [NUM_IN-1:0]     flag;
    logic [NUM_IN-1:0]     flag_next;
    logic [31:0]           stat_cleared;
    logic [31:0]           count;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [31:0]           off;
    logic                  is_io;
    logic                  wr_en;
    logic                  io_wr;
    io_sel_e               sel;
    logic [31:0]           rd_io;

    assign ram_idx = addr[DEPTH_LOG2+1:2];
    assign off     = 32'(addr[IO_BIT-1:2]);
    assign is_io   = addr[IO_BIT];
    assign wr_en   = we && (be != 4'b0000);
    assign io_wr   = wr_en && is_io;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        sel = SEL_NONE;
        if (off < 32'(OUT_BASE + NUM_OUT)) begin
            sel = SEL_OUT;
        end else if (off >= 32'(IN_BASE) && off < 32'(IN_BASE + NUM_IN)) begin
            sel = SEL_IN;
        end else if (off == 32'(STAT_OFF)) begin
            sel = SEL_STAT;
        end else if (off == 32'(CNT_OFF)) begin
            sel = SEL_CNT;
        end
    end

    // NOTE: the RAM has no reset; its contents survive reset and a reset-cycle
    // write is simply gated off.
    always_ff @(posedge clock) begin
        if (!reset && wr_en && !is_io) begin
            mem[ram_idx] <= byte_merge(mem[ram_idx], datain, be);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                out_reg[i] <= '0;
            end
        end else if (io_wr && sel == SEL_OUT) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (off == 32'(OUT_BASE + i)) begin
                    out_reg[i] <= byte_merge(out_reg[i], datain, be);
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
        assign out_ports[32*i +: 32] = out_reg[i];
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        io_input_sync #(
            .IN_W(IN_W)
        ) u_sync (
            .clock (clock),
            .reset (reset),
            .raw   (in_ports[IN_W*i +: IN_W]),
            .value (in_val[i]),
            .change(change[i])
        );
    end

    // A new change is OR-ed in after the clear, so set wins on a collision.
    assign stat_cleared = (io_wr && sel == SEL_STAT) ? w1c_merge(32'(flag), datain, be)
                                                     : 32'(flag);
    assign flag_next    = stat_cleared[NUM_IN-1:0] | change;

    always_ff @(posedge clock) begin
        if (reset) begin
            flag <= '0;
        end else begin
            flag <= flag_next;
        end
    end

    assign in_change = flag;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (io_wr && sel == SEL_CNT) begin
            count <= byte_merge(count, datain, be);
        end else begin
            count <= count + 32'd1;
        end
    end

    always_comb begin
        rd_io = '0;
        case (sel)
            SEL_OUT: begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (off == 32'(OUT_BASE + i)) rd_io = out_reg[i];
                end
            end
            SEL_IN: begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (off == 32'(IN_BASE + i)) rd_io = 32'(in_val[i]);
                end
            end
            SEL_STAT: rd_io = 32'(flag);
            SEL_CNT:  rd_io = count;
            default:  rd_io = '0;
        endcase
    end

    assign dataout = is_io ? rd_io : mem[ram_idx];

    logic unused_bits;
    assign unused_bits = ^{addr[31:IO_BIT+1], addr[1:0], stat_cleared[31:NUM_IN]};

endmodule

// File: tb/tb_sc_datamem_io.sv
// Directed self-checking bench for sc_datamem_io: default configuration plus
// a second instance with widened parameters.
module tb_sc_datamem_io;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   addr;
    logic [31:0]   datain;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   dataout;
    logic [95:0]   out_ports;
    logic [7:0]    in_ports;
    logic [0:0]    in_change;

    logic [31:0]   b_addr;
    logic [31:0]   b_datain;
    logic          b_we;
    logic [3:0]    b_be;
    logic [31:0]   b_dataout;
    logic [255:0]  b_out;
    logic [63:0]   b_in;
    logic [3:0]    b_change;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sc_datamem_io dut (
        .clock    (clock),
        .reset    (reset),
        .addr     (addr),
        .datain   (datain),
        .we       (we),
        .be       (be),
        .dataout  (dataout),
        .out_ports(out_ports),
        .in_ports (in_ports),
        .in_change(in_change)
    );

    sc_datamem_io #(
        .DEPTH_LOG2(6),
        .IO_BIT    (8),
        .NUM_OUT   (8),
        .NUM_IN    (4),
        .IN_W      (16)
    ) dut_big (
        .clock    (clock),
        .reset    (reset),
        .addr     (b_addr),
        .datain   (b_datain),
        .we       (b_we),
        .be       (b_be),
        .dataout  (b_dataout),
        .out_ports(b_out),
        .in_ports (b_in),
        .in_change(b_change)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        addr   = a;
        datain = d;
        be     = b;
        we     = 1'b1;
        tick();
        we     = 1'b0;
    endtask

    task automatic write_big(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        b_addr   = a;
        b_datain = d;
        b_be     = b;
        b_we     = 1'b1;
        tick();
        b_we     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (out_ports !== 96'h0) begin
            failures++;
            $display("FAIL reset_out_ports got=%h exp=%h", out_ports, 96'h0);
        end
        checks++;
        if (in_change !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_change got=%b exp=0", in_change);
        end
        addr = 32'hC4;
        #1;
        checks++;
        if (dataout !== 32'h0) begin
            failures++;
            $display("FAIL reset_counter got=%h exp=%h", dataout, 32'h0);
        end
        checks++;
        if (b_out !== 256'h0) begin
            failures++;
            $display("FAIL reset_big_out got=%h exp=0", b_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_ram();
        write_word(32'h0C, 32'h12345678, 4'b1111);
        addr = 32'h0C;
        #1;
        checks++;
        if (dataout !== 32'h12345678) begin
            failures++;
            $display("FAIL ram_sw got=%h exp=%h", dataout, 32'h12345678);
        end
        write_word(32'h0C, 32'hABABABAB, 4'b0100);
        checks++;
        if (dataout !== 32'h12AB5678) begin
            failures++;
            $display("FAIL ram_sb got=%h exp=%h", dataout, 32'h12AB5678);
        end
        write_word(32'h0C, 32'hFFFFFFFF, 4'b0000);
        checks++;
        if (dataout !== 32'h12AB5678) begin
            failures++;
            $display("FAIL ram_be0_noop got=%h exp=%h", dataout, 32'h12AB5678);
        end
        write_word(32'h00, 32'hCAFEF00D, 4'b1111);
        checks++;
        if (dataout !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL ram_word0 got=%h exp=%h", dataout, 32'hCAFEF00D);
        end
        addr = 32'h0C;
        #1;
        checks++;
        if (dataout !== 32'h12AB5678) begin
            failures++;
            $display("FAIL ram_word3_kept got=%h exp=%h", dataout, 32'h12AB5678);
        end
    endtask

    task automatic test_out_ports();
        write_word(32'h84, 32'hDEADBEEF, 4'b1111);
        checks++;
        if (out_ports !== {32'h0, 32'hDEADBEEF, 32'h0}) begin
            failures++;
            $display("FAIL out_port1 got=%h exp=%h", out_ports, {32'h0, 32'hDEADBEEF, 32'h0});
        end
        checks++;
        if (dataout !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL out_port1_read got=%h exp=%h", dataout, 32'hDEADBEEF);
        end
        write_word(32'h94, 32'h11111111, 4'b1111);
        checks++;
        if (out_ports !== {32'h0, 32'hDEADBEEF, 32'h0}) begin
            failures++;
            $display("FAIL out_off5_ignored got=%h exp=%h", out_ports, {32'h0, 32'hDEADBEEF, 32'h0});
        end
        checks++;
        if (dataout !== 32'h0) begin
            failures++;
            $display("FAIL out_off5_read got=%h exp=%h", dataout, 32'h0);
        end
        write_word(32'h88, 32'h123456FF, 4'b0001);
        checks++;
        if (out_ports !== {32'h000000FF, 32'hDEADBEEF, 32'h0}) begin
            failures++;
            $display("FAIL out_port2_byte got=%h exp=%h", out_ports, {32'h000000FF, 32'hDEADBEEF, 32'h0});
        end
        addr = 32'hA4;
        #1;
        checks++;
        if (dataout !== 32'h0) begin
            failures++;
            $display("FAIL in_missing_chan got=%h exp=%h", dataout, 32'h0);
        end
    endtask

    task automatic test_input_sync();
        addr = 32'hC0;
        #1;
        checks++;
        if (dataout !== 32'h0) begin
            failures++;
            $display("FAIL status_idle got=%h exp=%h", dataout, 32'h0);
        end
        in_ports = 8'h5A;
        addr     = 32'hA0;
        tick();
        checks++;
        if (dataout !== 32'h0) begin
            failures++;
            $display("FAIL in_edge_k got=%h exp=%h", dataout, 32'h0);
        end
        tick();
        checks++;
        if (dataout !== 32'h0000005A) begin
            failures++;
            $display("FAIL in_edge_k1 got=%h exp=%h", dataout, 32'h5A);
        end
        checks++;
        if (in_change !== 1'b0) begin
            failures++;
            $display("FAIL flag_edge_k1 got=%b exp=0", in_change);
        end
        tick();
        checks++;
        if (in_change !== 1'b1) begin
            failures++;
            $display("FAIL flag_edge_k2 got=%b exp=1", in_change);
        end
        addr = 32'hC0;
        #1;
        checks++;
        if (dataout !== 32'h1) begin
            failures++;
            $display("FAIL status_read got=%h exp=%h", dataout, 32'h1);
        end
        write_word(32'hC0, 32'h1, 4'b1111);
        checks++;
        if (in_change !== 1'b0) begin
            failures++;
            $display("FAIL flag_clear got=%b exp=0", in_change);
        end
        in_ports = 8'hA5;
        tick();
        tick();
        checks++;
        if (in_change !== 1'b0) begin
            failures++;
            $display("FAIL flag_before_collision got=%b exp=0", in_change);
        end
        write_word(32'hC0, 32'h1, 4'b1111);
        checks++;
        if (in_change !== 1'b1) begin
            failures++;
            $display("FAIL flag_set_wins got=%b exp=1", in_change);
        end
        write_word(32'hC0, 32'h1, 4'b1110);
        checks++;
        if (in_change !== 1'b1) begin
            failures++;
            $display("FAIL flag_clear_be_masked got=%b exp=1", in_change);
        end
        write_word(32'hC0, 32'h1, 4'b1111);
        checks++;
        if (in_change !== 1'b0) begin
            failures++;
            $display("FAIL flag_clear_again got=%b exp=0", in_change);
        end
    endtask

    task automatic test_counter();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        addr  = 32'hC4;
        #1;
        checks++;
        if (dataout !== 32'd0) begin
            failures++;
            $display("FAIL cnt_cycle0 got=%h exp=%h", dataout, 32'd0);
        end
        repeat (5) tick();
        checks++;
        if (dataout !== 32'd5) begin
            failures++;
            $display("FAIL cnt_cycle5 got=%h exp=%h", dataout, 32'd5);
        end
        write_word(32'hC4, 32'hFFFFFFFE, 4'b1111);
        checks++;
        if (dataout !== 32'hFFFFFFFE) begin
            failures++;
            $display("FAIL cnt_load got=%h exp=%h", dataout, 32'hFFFFFFFE);
        end
        tick();
        checks++;
        if (dataout !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL cnt_max got=%h exp=%h", dataout, 32'hFFFFFFFF);
        end
        tick();
        checks++;
        if (dataout !== 32'h0) begin
            failures++;
            $display("FAIL cnt_wrap got=%h exp=%h", dataout, 32'h0);
        end
        write_word(32'hC4, 32'hAAAA12BB, 4'b0010);
        checks++;
        if (dataout !== 32'h00001200) begin
            failures++;
            $display("FAIL cnt_byte_load got=%h exp=%h", dataout, 32'h00001200);
        end
    endtask

    task automatic test_reset_write();
        reset  = 1'b1;
        addr   = 32'h80;
        datain = 32'h55555555;
        be     = 4'b1111;
        we     = 1'b1;
        tick();
        checks++;
        if (out_ports !== 96'h0) begin
            failures++;
            $display("FAIL rst_out_write got=%h exp=%h", out_ports, 96'h0);
        end
        addr   = 32'h00;
        datain = 32'h77777777;
        tick();
        checks++;
        if (dataout !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL rst_ram_read_in_reset got=%h exp=%h", dataout, 32'hCAFEF00D);
        end
        we    = 1'b0;
        reset = 1'b0;
        tick();
        checks++;
        if (dataout !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL rst_ram_write_blocked got=%h exp=%h", dataout, 32'hCAFEF00D);
        end
        addr = 32'h0C;
        #1;
        checks++;
        if (dataout !== 32'h12AB5678) begin
            failures++;
            $display("FAIL rst_ram_survives got=%h exp=%h", dataout, 32'h12AB5678);
        end
        addr = 32'h84;
        #1;
        checks++;
        if (dataout !== 32'h0) begin
            failures++;
            $display("FAIL rst_out_read got=%h exp=%h", dataout, 32'h0);
        end
    endtask

    task automatic test_param_sweep();
        write_big(32'hFC, 32'h0BADC0DE, 4'b1111);
        write_big(32'h7C, 32'h31313131, 4'b1111);
        b_addr = 32'hFC;
        #1;
        checks++;
        if (b_dataout !== 32'h0BADC0DE) begin
            failures++;
            $display("FAIL big_ram63 got=%h exp=%h", b_dataout, 32'h0BADC0DE);
        end
        b_addr = 32'h7C;
        #1;
        checks++;
        if (b_dataout !== 32'h31313131) begin
            failures++;
            $display("FAIL big_ram31 got=%h exp=%h", b_dataout, 32'h31313131);
        end
        write_big(32'h11C, 32'h76543210, 4'b1111);
        checks++;
        if (b_out[255:224] !== 32'h76543210) begin
            failures++;
            $display("FAIL big_out7 got=%h exp=%h", b_out[255:224], 32'h76543210);
        end
        checks++;
        if (b_out[223:0] !== 224'h0) begin
            failures++;
            $display("FAIL big_out_others got=%h exp=0", b_out[223:0]);
        end
        b_in   = 64'hBEEF_0000_0000_0000;
        b_addr = 32'h12C;
        tick();
        tick();
        checks++;
        if (b_dataout !== 32'h0000BEEF) begin
            failures++;
            $display("FAIL big_in3 got=%h exp=%h", b_dataout, 32'h0000BEEF);
        end
        tick();
        checks++;
        if (b_change !== 4'b1000) begin
            failures++;
            $display("FAIL big_flag3 got=%b exp=%b", b_change, 4'b1000);
        end
        b_addr = 32'h140;
        #1;
        checks++;
        if (b_dataout !== 32'h8) begin
            failures++;
            $display("FAIL big_status got=%h exp=%h", b_dataout, 32'h8);
        end
    endtask

    initial begin
        reset    = 1'b1;
        addr     = '0;
        datain   = '0;
        we       = 1'b0;
        be       = '0;
        in_ports = '0;
        b_addr   = '0;
        b_datain = '0;
        b_we     = 1'b0;
        b_be     = '0;
        b_in     = '0;

        test_reset();
        test_ram();
        test_out_ports();
        test_input_sync();
        test_counter();
        test_reset_write();
        test_param_sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sc_datamem_io.md
Name: sc_datamem_io

Overview:
Parametrised data-memory and memory-mapped I/O block for the single-cycle CPU. It is the successor to the fixed 32-word RAM with three output ports and one input port. It adds the following:
- Configurable RAM depth.
- Configurable output and input channel counts.
- Byte-enable stores.
- Synchronised inputs with sticky change flags.
- A free-running cycle counter.

It sits between the CPU datapath (addr/datain/we/be from the ALU and control unit) and the board I/O.

Parameters:
DEPTH_LOG2, 5, RAM holds 2**DEPTH_LOG2 32-bit words; DEPTH_LOG2+2 <= IO_BIT required
IO_BIT, 7, address bit selecting I/O space (1) versus RAM (0); IO_BIT >= 7 required
NUM_OUT, 3, number of 32-bit output registers (1..8)
NUM_IN, 1, number of input channels (1..8)
IN_W, 8, width of each input channel (1..32), zero-extended on read

Ports:
clock  in  1  single system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
addr  in  32  byte address from ALU
datain  in  32  store data
we  in  1  store enable
be  in  4  byte enables, be[k] enables datain[8k+7:8k]
dataout  out  32  load data, combinational from addr
out_ports  out  NUM_OUT*32  output registers, channel i at [32i+31:32i]
in_ports  in  NUM_IN*IN_W  asynchronous board inputs, channel i at [IN_W*i+IN_W-1:IN_W*i]
in_change  out  NUM_IN  sticky change flags (mirror of status register)

Behaviour:
- Clock and reset: one clock and one reset. reset is synchronous and active-high; it is sampled only at the rising edge of clock.
- Reset values: out_ports=0, synchroniser stages=0, in_change=0, counter=0. RAM contents are not reset and survive reset unchanged.
- RAM index: addr[DEPTH_LOG2+1:2]. Bits between DEPTH_LOG2+2 and IO_BIT-1 are ignored (aliasing). addr[1:0] is ignored for indexing.
- I/O word offset: off = addr[IO_BIT-1:2].
  - off 0..NUM_OUT-1: output register, read/write.
  - off 8..8+NUM_IN-1: input channel, read-only; returns the synchronised value zero-extended.
  - off 16: status register. Bits [NUM_IN-1:0] are change flags, upper bits read 0. Write-1-to-clear, honouring be.
  - off 17: cycle counter, read/write; a write loads the value, honouring be.
  - Any other offset reads 0; writes are ignored.
- Reads: combinational, zero latency. RAM is an asynchronous-read array. dataout is selected by addr[IO_BIT]. During reset, dataout still reflects RAM and I/O state.
- Writes: take effect at the rising edge when we=1 and reset=0. Only bytes with be[k]=1 change. we=1 with be=0 is a no-op.
- Input path, per channel: s1<=raw, s2<=s1, s3<=s2 every cycle.
  - Reads return s2.
  - flag[i] <= flag[i] | (s2!=s3).
  - A raw change before edge k becomes readable after edge k+1; the flag sets at edge k+2.
- Counter: increments by 1 every cycle and wraps from 0xFFFFFFFF to 0. On a write cycle, the merged write value is loaded and the increment is skipped that cycle.
- Simultaneous set and clear of a change flag: set wins, so the flag stays 1.
- Reset asserted mid-operation: it overrides any write in the same cycle. A RAM write in the reset cycle is suppressed.

Decomposition:
- Shared package sc_io_pkg holds:
  - Offset constants OUT_BASE=0, IN_BASE=8, STAT_OFF=16, CNT_OFF=17.
  - Function byte_merge(old, new, be) used by RAM, output registers and counter.
  - Function W1C merge for the status register.
- One sub-module, io_input_sync: a per-channel 3-stage synchroniser with change detect. It is parametrised by IN_W and instantiated NUM_IN times via generate.

Test Plan:
1. Reset, then sw 0x12345678 to RAM word 3 (addr 0x0C, be=1111) → read 0x0C returns 0x12345678. Then sb 0xAB with be=0100 → read returns 0x12AB5678.
2. Write 0xDEADBEEF to addr 0x84 (out port 1) → out_ports[63:32]=0xDEADBEEF next cycle, other ports 0. Write to offset 5 → no port changes, read returns 0.
3. in_ports[7:0] 0x00→0x5A before edge k → read addr 0xA0 returns 0x5A after edge k+1; in_change[0]=1 after edge k+2. Write 0x1 to addr 0xC0 → flag clears. A clear coinciding with a new change → flag stays 1.
4. Reset released at cycle 0 → read 0xC4 at cycle n returns n. Write 0xFFFFFFFE → reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0x00000000 in the following cycles.
5. Assert reset with we=1 to addr 0x80 and to RAM word 0 → out port 0 stays 0; RAM word 0 keeps its prior value. Out ports read 0 after reset.
6. Parameter sweep (DEPTH_LOG2=6, IO_BIT=8, NUM_OUT=8, NUM_IN=4, IN_W=16) → addr 0xFC hits RAM word 63; addr 0x11C writes out port 7.
